// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit constants and the add-3 helper.
package bin2bcd_seq_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest legal BCD digit, used to saturate on overflow
  localparam logic [3:0] BCD_NINE   = 4'h9;

  // Digits at or above this value are corrected before each shift
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Double-dabble correction: a digit >= 5 would become >= 10 after the
  // shift, so adding 3 first makes the shift carry into the next digit.
  function automatic logic [3:0] adjDigit(input logic [3:0] digit);
    return (digit >= ADJ_THRESH) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus of the binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy, done and
// the registered result fields.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     digit_en;
  logic                  ovf;

  // Requester side (score logic / testbench)
  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  digit_en,
    input  ovf
  );

  // Converter side
  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output digit_en,
    output ovf
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Single-digit "if >= 5 then +3" corrector. Purely combinational; the
// top level instantiates one per BCD digit of the shift register.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction of one BCD digit
  always_comb begin
    digit_o = adjDigit(digit_i);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one input bit per
// clock. A conversion takes BIN_W shift cycles plus one cycle to register
// the result, saturates to all nines when the value does not fit in
// DIGITS digits, and produces a leading-zero mask for the display scanner.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_e              state_q,     state_d;
  logic [BIN_W-1:0]    binSr_q,     binSr_d;
  logic [BCD_W-1:0]    bcdSr_q,     bcdSr_d;
  logic                ovfSticky_q, ovfSticky_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                ovf_q,       ovf_d;
  logic [BCD_W-1:0]    bcd_q,       bcd_d;
  logic [DIGITS-1:0]   digitEn_q,   digitEn_d;

  logic [BCD_W-1:0]    bcdAdj;
  logic [DIGITS-1:0]   digitEnRaw;
  logic                acceptStart;
  logic                lastShift;

  // One add-3 corrector per digit of the BCD shift register
  for (genvar g = 0; g < DIGITS; g++) begin : gAdj
    bcd_digit_adj uAdj (
      .digit_i (bcdSr_q[4*g +: 4]),
      .digit_o (bcdAdj[4*g +: 4])
    );
  end

  // A digit is significant if it or any more-significant digit is nonzero
  always_comb begin : pDigitEn
    logic seen;
    seen       = 1'b0;
    digitEnRaw = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen          = seen | (bcdSr_q[4*i +: 4] != 4'd0);
      digitEnRaw[i] = seen;
    end
    digitEnRaw[0] = 1'b1;
  end

  // A new request is taken when idle or in the result cycle, never mid-shift
  always_comb begin
    acceptStart = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    lastShift   = (cnt_q == CNT_W'(BIN_W - 1));
  end

  // Sequencer next state, datapath updates and result capture
  always_comb begin
    state_d     = state_q;
    binSr_d     = binSr_q;
    bcdSr_d     = bcdSr_q;
    ovfSticky_d = ovfSticky_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    digitEn_d   = digitEn_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end

      ST_SHIFT: begin
        bcdSr_d     = {bcdAdj[BCD_W-2:0], binSr_q[BIN_W-1]};
        binSr_d     = {binSr_q[BIN_W-2:0], 1'b0};
        ovfSticky_d = ovfSticky_q | bcdAdj[BCD_W-1];
        cnt_d       = cnt_q + CNT_W'(1);
        if (lastShift) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end
      end

      ST_DONE: begin
        bcd_d     = ovfSticky_q ? {DIGITS{BCD_NINE}} : bcdSr_q;
        digitEn_d = ovfSticky_q ? {DIGITS{1'b1}} : digitEnRaw;
        ovf_d     = ovfSticky_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Loading a new operand overrides the working registers; the result
    // captured above in the DONE cycle still comes from the old operand.
    if (acceptStart) begin
      binSr_d     = bus.bin;
      bcdSr_d     = '0;
      ovfSticky_d = 1'b0;
      cnt_d       = '0;
      state_d     = ST_SHIFT;
      busy_d      = 1'b1;
    end
  end

  // State, datapath and output registers; reset aborts any conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      binSr_q     <= '0;
      bcdSr_q     <= '0;
      ovfSticky_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      digitEn_q   <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      binSr_q     <= binSr_d;
      bcdSr_q     <= bcdSr_d;
      ovfSticky_q <= ovfSticky_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      digitEn_q   <= digitEn_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.digit_en = digitEn_q;
  assign bus.ovf      = ovf_q;

endmodule
